// File: rtl/uart_rx_core_if.sv
// Serial-in / byte-out signal bundle for uart_rx_core.
`timescale 1ns/1ps
interface uart_rx_core_if;
   logic       i_uart_rx;
   logic [7:0] o_uart_data;
   logic       o_data_valid;

   modport master (output i_uart_rx, input o_uart_data, input o_data_valid);
   modport slave  (input i_uart_rx, output o_uart_data, output o_data_valid);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizes the raw line, centre-samples each bit and
// emits received bytes with a one-cycle valid strobe.
`timescale 1ns/1ps
module uart_rx_core #(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 9600
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_rx_core_if.slave  bus
);
   localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             sync1_q, rx_s;

   // rst_n is active-high despite its name
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         sync1_q <= 1'b1;
         rx_s    <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         sync1_q <= bus.i_uart_rx;
         rx_s    <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               idx_d = '0;
               state_d = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == BIT_M1) begin
               cnt_d = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == BIT_M1) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_HIGH: begin
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.o_uart_data  = data_q;
   assign bus.o_data_valid = valid_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_core;
   localparam int unsigned CLK_NS = 10;
   localparam int unsigned BIT_NS = 160;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned stray = 0;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] rxq[$];

   uart_rx_core_if bus();

   uart_rx_core #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #(CLK_NS/2) clk = ~clk;

   always @(negedge clk) begin
      if (bus.o_data_valid) rxq.push_back(bus.o_uart_data);
      if (!rst_n && !bus.o_data_valid && bus.o_uart_data !== prev_data) stray++;
      prev_data = bus.o_uart_data;
   end

   task automatic send_frame(input logic [7:0] b, input logic stop);
      bus.i_uart_rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         bus.i_uart_rx = b[i];
         #(BIT_NS);
      end
      bus.i_uart_rx = stop;
      #(BIT_NS);
      bus.i_uart_rx = 1'b1;
   endtask

   task automatic expect_one(input string name, input logic [7:0] exp);
      #(BIT_NS);
      @(negedge clk);
      total++;
      if (rxq.size() !== 1) begin
         bad++; $display("FAIL %s pulses: got %0d want 1", name, rxq.size());
      end else begin
         total++;
         if (rxq[0] !== exp) begin
            bad++; $display("FAIL %s pulse data: got %h want %h", name, rxq[0], exp);
         end
      end
      total++;
      if (bus.o_uart_data !== exp) begin
         bad++; $display("FAIL %s data: got %h want %h", name, bus.o_uart_data, exp);
      end
   endtask

   task automatic test_reset();
      bus.i_uart_rx = 1'b1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      total++;
      if (bus.o_uart_data !== 8'h00) begin
         bad++; $display("FAIL reset data: got %h want 00", bus.o_uart_data);
      end
      total++;
      if (bus.o_data_valid !== 1'b0) begin
         bad++; $display("FAIL reset valid: got %b want 0", bus.o_data_valid);
      end
      rst_n = 1'b0;
      rxq.delete();
      #(5 * BIT_NS);
      @(negedge clk);
      total++;
      if (bus.o_uart_data !== 8'h00) begin
         bad++; $display("FAIL idle data: got %h want 00", bus.o_uart_data);
      end
      total++;
      if (rxq.size() !== 0) begin
         bad++; $display("FAIL idle pulses: got %0d want 0", rxq.size());
      end
   endtask

   task automatic test_single();
      rxq.delete();
      send_frame(8'hA5, 1'b1);
      expect_one("single_a5", 8'hA5);
   endtask

   task automatic test_second_hold();
      rxq.delete();
      send_frame(8'h0F, 1'b1);
      expect_one("second_0f", 8'h0F);
      rxq.delete();
      #(20 * BIT_NS);
      @(negedge clk);
      total++;
      if (bus.o_uart_data !== 8'h0F || rxq.size() !== 0) begin
         bad++; $display("FAIL hold: got data %h pulses %0d want 0f/0", bus.o_uart_data, rxq.size());
      end
   endtask

   task automatic test_back_to_back();
      rxq.delete();
      send_frame(8'h55, 1'b1);
      send_frame(8'h00, 1'b1);
      #(BIT_NS);
      @(negedge clk);
      total++;
      if (rxq.size() !== 2) begin
         bad++; $display("FAIL b2b pulses: got %0d want 2", rxq.size());
      end else begin
         total++;
         if (rxq[0] !== 8'h55 || rxq[1] !== 8'h00) begin
            bad++; $display("FAIL b2b order: got %h,%h want 55,00", rxq[0], rxq[1]);
         end
      end
   endtask

   task automatic test_glitch();
      rxq.delete();
      bus.i_uart_rx = 1'b0;
      #(3 * CLK_NS);
      bus.i_uart_rx = 1'b1;
      #(3 * BIT_NS);
      @(negedge clk);
      total++;
      if (rxq.size() !== 0 || bus.o_uart_data !== 8'h00) begin
         bad++; $display("FAIL glitch: got pulses %0d data %h want 0/00", rxq.size(), bus.o_uart_data);
      end
      rxq.delete();
      send_frame(8'h3C, 1'b1);
      expect_one("after_glitch_3c", 8'h3C);
   endtask

   task automatic test_framing();
      rxq.delete();
      send_frame(8'h81, 1'b0);
      bus.i_uart_rx = 1'b0;
      #(2 * BIT_NS);
      bus.i_uart_rx = 1'b1;
      #(2 * BIT_NS);
      @(negedge clk);
      total++;
      if (rxq.size() !== 0 || bus.o_uart_data !== 8'h3C) begin
         bad++; $display("FAIL framing: got pulses %0d data %h want 0/3c", rxq.size(), bus.o_uart_data);
      end
      rxq.delete();
      send_frame(8'h7E, 1'b1);
      expect_one("after_framing_7e", 8'h7E);
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      b = 8'hF0;
      rxq.delete();
      bus.i_uart_rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         bus.i_uart_rx = b[i];
         if (i == 4) begin
            #(BIT_NS/2);
            rst_n = 1'b1;
            #(3 * CLK_NS);
            rst_n = 1'b0;
            #(BIT_NS - BIT_NS/2 - 3 * CLK_NS);
         end else begin
            #(BIT_NS);
         end
      end
      bus.i_uart_rx = 1'b1;
      #(3 * BIT_NS);
      @(negedge clk);
      total++;
      if (rxq.size() !== 0) begin
         bad++; $display("FAIL reset_mid pulses: got %0d want 0", rxq.size());
      end
      total++;
      if (bus.o_uart_data !== 8'h00) begin
         bad++; $display("FAIL reset_mid data: got %h want 00", bus.o_uart_data);
      end
      rxq.delete();
      send_frame(8'hC3, 1'b1);
      expect_one("after_reset_c3", 8'hC3);
      total++;
      if (stray !== 0) begin
         bad++; $display("FAIL data_without_pulse: got %0d changes want 0", stray);
      end
   endtask

   initial begin
      bus.i_uart_rx = 1'b1;
      test_reset();
      test_single();
      test_second_hold();
      test_back_to_back();
      test_glitch();
      test_framing();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
